// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the MIPS pipeline hazard logic.
// The optional perf counters in hazard_scoreboard are enabled by defining HAZARD_PERF_EN.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } haz_state_t;

    // Primary opcode field values seen by decode.
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] LL   = 6'h30;
    localparam logic [5:0] SC   = 6'h38;
    localparam logic [5:0] HALT = 6'h3F;

    localparam int CNT_BITS = 3;
    localparam int DRAIN_W  = 4;

    // SC also writes rt (the success flag) through the load return path.
    function automatic logic is_load_op(input logic [5:0] op);
        return (op == LW) || (op == LL) || (op == SC);
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Per-register pending-load countdown and the load-use hit for the instruction in D.
module load_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int REG_W    = $clog2(NREGS),
    parameter int LOAD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             issue_fire,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs,
    input  logic             dec_uses_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_uses_rt,
    input  logic             dec_wen,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_is_load,
    input  logic             mem_wait,
    output logic             lu_hit
);

    logic [NREGS-1:0] busy;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_r0
                assign busy[gi] = 1'b0;
            end else begin : g_trk
                logic [CNT_BITS-1:0] cnt_q;
                logic [CNT_BITS-1:0] cnt_d;

                // A new writer overrides whatever countdown is in flight for this register.
                always_comb begin
                    cnt_d = cnt_q;
                    if (issue_fire && dec_wen && (dec_rd == REG_W'(gi))) begin
                        cnt_d = dec_is_load ? CNT_BITS'(LOAD_LAT) : '0;
                    end else if (mem_wait) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                always_ff @(posedge CLK) begin
                    if (RST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign busy[gi] = (cnt_q != '0);
            end
        end
    endgenerate

    assign lu_hit = dec_valid && ((dec_uses_rs && busy[dec_rs]) ||
                                  (dec_uses_rt && busy[dec_rt]));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load scoreboard, memory-wait stalls, branch flushes, halt drain.
// Stall/flush perf counters are present only when HAZARD_PERF_EN is defined.
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int REG_W     = $clog2(NREGS),
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 3
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs,
    input  logic             dec_uses_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_uses_rt,
    input  logic             dec_wen,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_is_load,
    input  logic             dec_is_halt,
    input  logic             br_taken,
    input  logic             mem_wait,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             stall_de,
    output logic             flush_de,
    output logic             stall_em,
    output logic             flush_em,
    output logic             stall_mw,
    output logic             issue_fire,
    output logic             halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_mw,
    output logic [CNT_W-1:0] perf_fl
`endif
);

    haz_state_t         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               lu_hit;

    load_scoreboard #(
        .NREGS    (NREGS),
        .REG_W    (REG_W),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .CLK         (CLK),
        .RST         (RST),
        .issue_fire  (issue_fire),
        .dec_valid   (dec_valid),
        .dec_rs      (dec_rs),
        .dec_uses_rs (dec_uses_rs),
        .dec_rt      (dec_rt),
        .dec_uses_rt (dec_uses_rt),
        .dec_wen     (dec_wen),
        .dec_rd      (dec_rd),
        .dec_is_load (dec_is_load),
        .mem_wait    (mem_wait),
        .lu_hit      (lu_hit)
    );

    // Priority mux; outputs are forced quiet while reset is held.
    always_comb begin
        stall_fd   = 1'b0;
        flush_fd   = 1'b0;
        stall_de   = 1'b0;
        flush_de   = 1'b0;
        stall_em   = 1'b0;
        flush_em   = 1'b0;
        stall_mw   = 1'b0;
        issue_fire = 1'b0;
        halt       = 1'b0;
        if (RST) begin
            halt = 1'b0;
        end else if (state_q == HALTED) begin
            stall_fd = 1'b1;
            stall_de = 1'b1;
            stall_em = 1'b1;
            stall_mw = 1'b1;
            halt     = 1'b1;
        end else if (mem_wait) begin
            stall_fd = 1'b1;
            stall_de = 1'b1;
            stall_em = 1'b1;
            stall_mw = 1'b1;
        end else if (state_q == DRAIN) begin
            stall_fd = 1'b1;
            flush_de = 1'b1;
        end else if (br_taken) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (lu_hit) begin
            stall_fd = 1'b1;
            flush_de = 1'b1;
        end else begin
            issue_fire = dec_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (issue_fire && dec_is_halt) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_W'(DRAIN_CYC);
                end
            end
            DRAIN: begin
                if (!mem_wait) begin
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             lu_cyc, mw_cyc, fl_cyc;
    logic [CNT_W-1:0] perf_lu_q, perf_mw_q, perf_fl_q;

    assign mw_cyc = (state_q != HALTED) && mem_wait;
    assign fl_cyc = (state_q == RUN) && !mem_wait && br_taken;
    assign lu_cyc = (state_q == RUN) && !mem_wait && !br_taken && lu_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_lu_q <= '0;
            perf_mw_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (lu_cyc && !(&perf_lu_q)) perf_lu_q <= perf_lu_q + 1'b1;
            if (mw_cyc && !(&perf_mw_q)) perf_mw_q <= perf_mw_q + 1'b1;
            if (fl_cyc && !(&perf_fl_q)) perf_fl_q <= perf_fl_q + 1'b1;
        end
    end

    assign perf_lu = perf_lu_q;
    assign perf_mw = perf_mw_q;
    assign perf_fl = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard; two instances cover LOAD_LAT=1 and LOAD_LAT=2.
module tb_hazard_scoreboard;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       dec_valid = 1'b0, dec_uses_rs = 1'b0, dec_uses_rt = 1'b0, dec_wen = 1'b0;
    logic [4:0] dec_rs = '0, dec_rt = '0, dec_rd = '0;
    logic       dec_is_load = 1'b0, dec_is_halt = 1'b0, br_taken = 1'b0, mem_wait = 1'b0;

    logic [8:0] out1, out2;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    // Output vector order: stall_fd flush_fd stall_de flush_de stall_em flush_em stall_mw issue halt
    localparam logic [8:0] IDLE = 9'b000000000;
    localparam logic [8:0] ISS  = 9'b000000010;
    localparam logic [8:0] BUB  = 9'b100100000;
    localparam logic [8:0] BRF  = 9'b010100000;
    localparam logic [8:0] MWS  = 9'b101010100;
    localparam logic [8:0] HLT  = 9'b101010101;

`ifdef HAZARD_PERF_EN
    logic [31:0] plu1, pmw1, pfl1, plu2, pmw2, pfl2;
`endif

    hazard_scoreboard #(.NREGS(32), .LOAD_LAT(1), .DRAIN_CYC(3)) u_lat1 (
        .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_uses_rs(dec_uses_rs),
        .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .dec_wen(dec_wen), .dec_rd(dec_rd),
        .dec_is_load(dec_is_load), .dec_is_halt(dec_is_halt), .br_taken(br_taken),
        .mem_wait(mem_wait), .stall_fd(out1[8]), .flush_fd(out1[7]), .stall_de(out1[6]),
        .flush_de(out1[5]), .stall_em(out1[4]), .flush_em(out1[3]), .stall_mw(out1[2]),
        .issue_fire(out1[1]), .halt(out1[0])
`ifdef HAZARD_PERF_EN
        , .perf_lu(plu1), .perf_mw(pmw1), .perf_fl(pfl1)
`endif
    );

    hazard_scoreboard #(.NREGS(32), .LOAD_LAT(2), .DRAIN_CYC(3)) u_lat2 (
        .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_uses_rs(dec_uses_rs),
        .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .dec_wen(dec_wen), .dec_rd(dec_rd),
        .dec_is_load(dec_is_load), .dec_is_halt(dec_is_halt), .br_taken(br_taken),
        .mem_wait(mem_wait), .stall_fd(out2[8]), .flush_fd(out2[7]), .stall_de(out2[6]),
        .flush_de(out2[5]), .stall_em(out2[4]), .flush_em(out2[3]), .stall_mw(out2[2]),
        .issue_fire(out2[1]), .halt(out2[0])
`ifdef HAZARD_PERF_EN
        , .perf_lu(plu2), .perf_mw(pmw2), .perf_fl(pfl2)
`endif
    );

    typedef struct {
        string      name;
        bit         dut;   // 0: LOAD_LAT=1 instance, 1: LOAD_LAT=2 instance
        bit         rst, valid, urs, urt, wen, ld, hlt, br, mw;
        logic [4:0] rs, rt, rd;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input bit d, input bit rst, input bit valid,
                                input logic [4:0] rs, input bit urs, input logic [4:0] rt,
                                input bit urt, input bit wen, input logic [4:0] rd, input bit ld,
                                input bit hlt, input bit br, input bit mw, input logic [8:0] exp);
        vec_t v;
        v.name = n; v.dut = d; v.rst = rst; v.valid = valid; v.rs = rs; v.urs = urs;
        v.rt = rt; v.urt = urt; v.wen = wen; v.rd = rd; v.ld = ld; v.hlt = hlt;
        v.br = br; v.mw = mw; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle of inputs after the edge, compare at the falling edge.
    task automatic run_vec(input vec_t v);
        logic [8:0] act;
        @(posedge CLK);
        #1;
        RST = v.rst; dec_valid = v.valid; dec_rs = v.rs; dec_uses_rs = v.urs;
        dec_rt = v.rt; dec_uses_rt = v.urt; dec_wen = v.wen; dec_rd = v.rd;
        dec_is_load = v.ld; dec_is_halt = v.hlt; br_taken = v.br; mem_wait = v.mw;
        @(negedge CLK);
        act = v.dut ? out2 : out1;
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s (lat%0d): got %b expected %b", v.name, v.dut ? 2 : 1, act, v.exp);
        end else begin
            $display("ok   %s (lat%0d): out=%b", v.name, v.dut ? 2 : 1, act);
        end
    endtask

    initial begin
        //        name          d  rst vld rs urs rt urt wen rd ld hlt br mw exp
        vecs.push_back(mk("reset_l1",    0, 1, 1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0, IDLE));
        vecs.push_back(mk("reset_l2",    1, 1, 1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 1, 1, 1, IDLE));
        // LW r5; dependent ADD stalls exactly one cycle at LOAD_LAT=1
        vecs.push_back(mk("lw_r5",       0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("add_bubble",  0, 0, 1, 5'd5, 1, 5'd2, 1, 1, 5'd6, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("add_issue",   0, 0, 1, 5'd5, 1, 5'd2, 1, 1, 5'd6, 0, 0, 0, 0, ISS));
        vecs.push_back(mk("add_again",   0, 0, 1, 5'd5, 1, 5'd6, 1, 1, 5'd7, 0, 0, 0, 0, ISS));
        // LOAD_LAT=2: SW reading rt=r7 gets two bubbles; r0 never hazards
        vecs.push_back(mk("rst_a",       1, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("lw_r7",       1, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("sw_bub1",     1, 0, 1, 5'd2, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("sw_bub2",     1, 0, 1, 5'd2, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("sw_issue",    1, 0, 1, 5'd2, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, ISS));
        vecs.push_back(mk("lw_r0",       1, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("use_r0",      1, 0, 1, 5'd0, 1, 5'd0, 1, 1, 5'd8, 0, 0, 0, 0, ISS));
        // mem_wait during the dependent stall holds the countdown
        vecs.push_back(mk("rst_b",       0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("lw_r5_b",     0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("mw_1",        0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 0, 1, MWS));
        vecs.push_back(mk("mw_2",        0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 0, 1, MWS));
        vecs.push_back(mk("mw_3",        0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 0, 1, MWS));
        vecs.push_back(mk("mw_bubble",   0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("mw_issue",    0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 0, 0, ISS));
        // Branch beats load-use; mem_wait beats branch
        vecs.push_back(mk("rst_c",       0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("lw_r5_c",     0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("br_over_lu",  0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 1, 0, BRF));
        vecs.push_back(mk("br_and_mw",   0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 1, 1, MWS));
        vecs.push_back(mk("br_plain",    0, 0, 1, 5'd3, 1, 5'd0, 0, 1, 5'd6, 0, 0, 1, 0, BRF));
        vecs.push_back(mk("after_br",    0, 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0, 0, 0, 0, ISS));
        // Unread source fields and empty D never stall
        vecs.push_back(mk("lw_r9",       0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd9, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("rs_unused",   0, 0, 1, 5'd9, 0, 5'd3, 1, 1, 5'd4, 0, 0, 0, 0, ISS));
        vecs.push_back(mk("lw_r9_2",     0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd9, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("d_empty",     0, 0, 0, 5'd9, 1, 5'd9, 1, 1, 5'd4, 0, 0, 0, 0, IDLE));
        // Younger ALU writer clears the pending load on r4 (LOAD_LAT=2)
        vecs.push_back(mk("rst_d",       1, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("lw_r4",       1, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 1, 0, 0, 0, ISS));
        vecs.push_back(mk("addi_r4",     1, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 0, 0, 0, 0, ISS));
        vecs.push_back(mk("use_r4",      1, 0, 1, 5'd4, 1, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, ISS));
        // HALT drain with one mem_wait cycle, then sticky halt
        vecs.push_back(mk("rst_e",       0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("halt_issue",  0, 0, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, ISS));
        vecs.push_back(mk("drain_1",     0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("drain_mw",    0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 1, MWS));
        vecs.push_back(mk("drain_br",    0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 1, 0, BUB));
        vecs.push_back(mk("drain_last",  0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("halted",      0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 0, HLT));
        vecs.push_back(mk("halted_mwbr", 0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 1, 1, HLT));
        // Reset in the middle of a drain returns to RUN
        vecs.push_back(mk("rst_f",       0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("halt_again",  0, 0, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, ISS));
        vecs.push_back(mk("drain_again", 0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 0, BUB));
        vecs.push_back(mk("rst_drain",   0, 1, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 0, IDLE));
        vecs.push_back(mk("run_again",   0, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 0, 0, 0, ISS));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Variable-length mem_wait during a LOAD_LAT=2 dependent stall
        for (int k = 1; k <= 3; k++) begin
            run_vec(mk("mwk_rst", 1, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, IDLE));
            run_vec(mk("mwk_lw_r3", 1, 0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd3, 1, 0, 0, 0, ISS));
            for (int j = 0; j < k; j++) begin
                run_vec(mk("mwk_hold", 1, 0, 1, 5'd2, 1, 5'd3, 1, 1, 5'd8, 0, 0, 0, 1, MWS));
            end
            run_vec(mk("mwk_bub1", 1, 0, 1, 5'd2, 1, 5'd3, 1, 1, 5'd8, 0, 0, 0, 0, BUB));
            run_vec(mk("mwk_bub2", 1, 0, 1, 5'd2, 1, 5'd3, 1, 1, 5'd8, 0, 0, 0, 0, BUB));
            run_vec(mk("mwk_issue", 1, 0, 1, 5'd2, 1, 5'd3, 1, 1, 5'd8, 0, 0, 0, 0, ISS));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
